multiplicador_secuencial: RTL and testbench

- Parametrised iterative shift-add multiplier, successor to the fixed 8x8 combinational multiplicador.
- Trades area for latency and processes BITS_PER_CYCLE multiplier bits per clock.
- Supports unsigned and two's-complement signed operands, selected per operation.
- Sits in the datapath helper modules; valid/ready handshakes on input and output let it sit behind the ALU issue logic.

---
 rtl/multiplicador_pkg.sv | 22 ++
 rtl/multiplicador_secuencial_if.sv | 28 ++
 rtl/multiplicador_paso.sv | 27 ++
 rtl/multiplicador_secuencial.sv | 136 +++++++++++++
 tb/tb_multiplicador_secuencial.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/multiplicador_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   mult_state_t : controller states IDLE / BUSY / DONE
//   MAX_WIDTH    : widest operand any instance may use
//   abs_mag()    : two's-complement magnitude at MAX_WIDTH bits; callers
//                  sign-extend on the way in and truncate on the way out.
package multiplicador_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // The most negative value maps onto its own bit pattern, which read as
  // unsigned is exactly its magnitude, so no extra bit is needed.
  function automatic logic [MAX_WIDTH-1:0] abs_mag(input logic signed [MAX_WIDTH-1:0] value);
    return value[MAX_WIDTH-1] ? (~value) + MAX_WIDTH'(1) : value;
  endfunction

endpackage

// File: rtl/multiplicador_secuencial_if.sv
// Operand/product handshake bundle for multiplicador_secuencial.
//   in_valid/in_ready   : operand handshake (signed_mode, input_a, input_b)
//   out_valid/out_ready : product handshake (output_s, 2*WIDTH bits)
//   master : the issuing side; slave : the multiplier.
interface multiplicador_secuencial_if #(
  parameter int WIDTH = 8
) ();

  logic               in_valid;
  logic               in_ready;
  logic               signed_mode;
  logic [WIDTH-1:0]   input_a;
  logic [WIDTH-1:0]   input_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] output_s;

  modport master (
    output in_valid, signed_mode, input_a, input_b, out_ready,
    input  in_ready, out_valid, output_s
  );

  modport slave (
    input  in_valid, signed_mode, input_a, input_b, out_ready,
    output in_ready, out_valid, output_s
  );

endinterface

// File: rtl/multiplicador_paso.sv
// One combinational shift-add step.
//   acc          : running 2*WIDTH-bit partial sum
//   multiplicand : unsigned multiplicand magnitude
//   slice        : next BITS_PER_CYCLE multiplier bits
//   shift        : weight of slice bit 0 within the multiplier
//   next_acc     : acc + (multiplicand * slice) << shift
module multiplicador_paso #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1,
  parameter int SHIFT_W        = 3
) (
  input  logic [2*WIDTH-1:0]        acc,
  input  logic [WIDTH-1:0]          multiplicand,
  input  logic [BITS_PER_CYCLE-1:0] slice,
  input  logic [SHIFT_W-1:0]        shift,
  output logic [2*WIDTH-1:0]        next_acc
);

  logic [2*WIDTH-1:0] partial;

  // Magnitude products never exceed 2*WIDTH bits, so the sum cannot carry out.
  always_comb begin
    partial  = (2*WIDTH)'(multiplicand) * (2*WIDTH)'(slice);
    next_acc = acc + (partial << shift);
  end

endmodule

// File: rtl/multiplicador_secuencial.sv
// Iterative shift-add multiplier, unsigned or two's-complement per operation.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : slave side of multiplicador_secuencial_if (operands in,
//                product out, valid/ready on both)
// Signed operands are reduced to magnitudes at capture; the sign is applied
// once, on the final BUSY edge, before the product is registered.
module multiplicador_secuencial
  import multiplicador_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  multiplicador_secuencial_if.slave   bus
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam int SH_W  = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("multiplicador_secuencial: WIDTH must be in 2..32");
  end
  if (BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
    $error("multiplicador_secuencial: BITS_PER_CYCLE must divide WIDTH");
  end

  mult_state_t        state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [SH_W-1:0]    shift_q, shift_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               neg_q, neg_d;
  logic               in_ready_q, in_ready_d;
  logic [2*WIDTH-1:0] step_acc;

  multiplicador_paso #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .SHIFT_W        (SH_W)
  ) u_paso (
    .acc          (acc_q),
    .multiplicand (mcand_q),
    .slice        (mplier_q[BITS_PER_CYCLE-1:0]),
    .shift        (shift_q),
    .next_acc     (step_acc)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d   = state_q;
    count_d   = count_q;
    shift_d   = shift_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    product_d = product_q;
    neg_d     = neg_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          if (bus.signed_mode) begin
            mcand_d  = WIDTH'(abs_mag(MAX_WIDTH'($signed(bus.input_a))));
            mplier_d = WIDTH'(abs_mag(MAX_WIDTH'($signed(bus.input_b))));
            neg_d    = bus.input_a[WIDTH-1] ^ bus.input_b[WIDTH-1];
          end else begin
            mcand_d  = bus.input_a;
            mplier_d = bus.input_b;
            neg_d    = 1'b0;
          end
          acc_d   = '0;
          shift_d = '0;
          count_d = CNT_W'(STEPS);
          state_d = BUSY;
        end
      end
      BUSY: begin
        // STEPS accumulate edges, then one edge to apply the sign: keeps the
        // adder and the negation off the same path.
        if (count_q != '0) begin
          acc_d    = step_acc;
          mplier_d = mplier_q >> BITS_PER_CYCLE;
          shift_d  = shift_q + SH_W'(BITS_PER_CYCLE);
          count_d  = count_q - CNT_W'(1);
        end else begin
          product_d = neg_q ? (~acc_q) + (2*WIDTH)'(1) : acc_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered so it stays low until the first edge after reset release.
    in_ready_d = (state_d == IDLE);
  end

  // NOTE: every register here, datapath included, is cleared by reset, so an
  // aborted operation leaves nothing behind and output_s reads 0 immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      shift_q    <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      product_q  <= '0;
      neg_q      <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments: every register samples pre-edge values.
      state_q    <= state_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      product_q  <= product_d;
      neg_q      <= neg_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q == DONE);
  assign bus.output_s  = product_q;

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Self-checking bench for multiplicador_secuencial: an 8x8 BITS_PER_CYCLE=1
// instance and a 16x16 BITS_PER_CYCLE=4 instance, sharing clock and reset.
// Expected products come from a behavioural model and pass through a queue.
module tb_multiplicador_secuencial;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multiplicador_secuencial_if #(.WIDTH(8))  bus8 ();
  multiplicador_secuencial_if #(.WIDTH(16)) bus16 ();

  multiplicador_secuencial #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  multiplicador_secuencial #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] model(input longint a, input longint b);
    longint p;
    p = a * b;
    return p[31:0];
  endfunction

  // Issues one 8-bit operation, scrambles the inputs mid-operation, checks
  // latency and product, optionally holds out_ready low for 'hold' cycles
  // (with a rejected in_valid pulse in DONE), then checks the return to IDLE.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic sm, input int hold);
    int          edges;
    logic [31:0] exp;
    longint      va, vb;
    va = sm ? longint'($signed(a)) : longint'(a);
    vb = sm ? longint'($signed(b)) : longint'(b);
    check({tag, "_in_ready_idle"}, 32'(bus8.in_ready), 32'd1);
    bus8.input_a     = a;
    bus8.input_b     = b;
    bus8.signed_mode = sm;
    bus8.in_valid    = 1'b1;
    bus8.out_ready   = (hold == 0);
    exp_q.push_back(model(va, vb));
    @(posedge clk); #1;
    bus8.in_valid    = 1'b0;
    bus8.input_a     = ~a;
    bus8.input_b     = b + 8'd1;
    bus8.signed_mode = ~sm;
    edges = 0;
    while (!bus8.out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_latency"}, 32'(edges), 32'd9);
    exp = exp_q.pop_front();
    check({tag, "_product"}, 32'(bus8.output_s), 32'(exp[15:0]));
    for (int i = 0; i < hold; i++) begin
      bus8.in_valid = (i == 0);
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      check({tag, "_hold_valid"}, 32'(bus8.out_valid), 32'd1);
      check({tag, "_hold_product"}, 32'(bus8.output_s), 32'(exp[15:0]));
      check({tag, "_hold_in_ready"}, 32'(bus8.in_ready), 32'd0);
    end
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, 32'(bus8.out_valid), 32'd0);
    check({tag, "_product_kept"}, 32'(bus8.output_s), 32'(exp[15:0]));
    check({tag, "_back_idle"}, 32'(bus8.in_ready), 32'd1);
  endtask

  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic sm);
    int          edges;
    logic [31:0] exp;
    longint      va, vb;
    va = sm ? longint'($signed(a)) : longint'(a);
    vb = sm ? longint'($signed(b)) : longint'(b);
    bus16.input_a     = a;
    bus16.input_b     = b;
    bus16.signed_mode = sm;
    bus16.in_valid    = 1'b1;
    bus16.out_ready   = 1'b1;
    exp_q.push_back(model(va, vb));
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    edges = 0;
    while (!bus16.out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_latency"}, 32'(edges), 32'd5);
    exp = exp_q.pop_front();
    check({tag, "_product"}, bus16.output_s, exp);
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, 32'(bus16.out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus8.in_valid = 1'b0;  bus8.signed_mode = 1'b0;
    bus8.input_a  = '0;    bus8.input_b     = '0;   bus8.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.signed_mode = 1'b0;
    bus16.input_a  = '0;   bus16.input_b     = '0;  bus16.out_ready = 1'b1;

    #2;
    check("rst_in_ready", 32'(bus8.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_output_s", 32'(bus8.output_s), 32'd0);
    check("rst16_out_valid", 32'(bus16.out_valid), 32'd0);

    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("release_in_ready_low", 32'(bus8.in_ready), 32'd0);
    @(posedge clk); #1;
    check("release_in_ready_high", 32'(bus8.in_ready), 32'd1);

    run8("u_8x2",     8'd8,   8'd2,   1'b0, 0);
    run8("u_255x255", 8'd255, 8'd255, 1'b0, 0);
    run8("s_m3x4",    8'hFD,  8'd4,   1'b1, 0);
    run8("s_m128sq",  8'h80,  8'h80,  1'b1, 0);
    run8("s_m1x127",  8'hFF,  8'h7F,  1'b1, 0);
    run8("u_0x200",   8'd0,   8'd200, 1'b0, 0);
    run8("bp_16x2",   8'd16,  8'd2,   1'b0, 5);

    // No operation may have been latched while DONE was stalled.
    @(posedge clk); #1;
    check("bp_no_phantom", 32'(bus8.out_valid), 32'd0);

    // Reset on the 4th BUSY cycle: outputs clear without a clock edge.
    bus8.input_a = 8'd7; bus8.input_b = 8'd9; bus8.signed_mode = 1'b0;
    bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("midrst_output_s", 32'(bus8.output_s), 32'd0);
    check("midrst_in_ready", 32'(bus8.in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("midrst_release_low", 32'(bus8.in_ready), 32'd0);
    @(posedge clk); #1;
    check("midrst_release_high", 32'(bus8.in_ready), 32'd1);
    check("midrst_nothing_out", 32'(bus8.out_valid), 32'd0);
    run8("after_rst_3x4", 8'd3, 8'd4, 1'b0, 0);

    run16("w_1000sq",  16'd1000, 16'd1000, 1'b0);
    run16("w_m1000x7", 16'hFC18, 16'd7,    1'b1);
    run16("w_ffff_sq", 16'hFFFF, 16'hFFFF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
